// File: rtl/stage_1.sv
// Instruction fetch stage: keeps the fetch PC, runs one outstanding request at a time on the
// instruction-memory port and buffers {pc, inst} pairs in a small prefetch FIFO for decode.
module stage_1 #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    input  logic        i_stall,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [31:0] Nop = 32'h0000_0013;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     f_pc_q, f_pc_d;
    logic [31:0]     r_pc_q, r_pc_d;
    logic            discard_q, discard_d;
    logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]     fifo_inst_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            push;
    logic            pop;
    logic [31:0]     b_target;

    assign b_target = i_b_pc & 32'hFFFF_FFFC;

    // A redirect wins over both FIFO ports; a response is kept only if it is not stale.
    assign o_valid = (count_q != '0);
    assign pop     = o_valid & ~i_stall & ~i_b_taken;
    assign push    = (state_q == StResp) & i_mem_valid & ~discard_q & ~i_b_taken;

    assign o_mem_req  = (state_q == StReq);
    assign o_mem_addr = f_pc_q;
    assign o_inst     = fifo_inst_q[rd_ptr_q];
    assign o_pc       = fifo_pc_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (i_b_taken) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        f_pc_d    = f_pc_q;
        r_pc_d    = r_pc_q;
        discard_d = discard_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (i_mem_gnt) begin
                    state_d = StResp;
                    if (i_b_taken) begin
                        f_pc_d    = b_target;
                        discard_d = 1'b1;
                    end else begin
                        r_pc_d = f_pc_q;
                        f_pc_d = f_pc_q + 32'd4;
                    end
                end else if (i_b_taken) begin
                    f_pc_d = b_target;
                end
            end
            StResp: begin
                if (i_mem_valid) begin
                    discard_d = 1'b0;
                    if (i_b_taken) begin
                        f_pc_d = b_target;
                    end
                    // Only request again when the next response is guaranteed a free slot.
                    if (push && (count_d == FullCnt)) begin
                        state_d = StHold;
                    end else begin
                        state_d = StReq;
                    end
                end else if (i_b_taken) begin
                    discard_d = 1'b1;
                    f_pc_d    = b_target;
                end
            end
            StHold: begin
                if (i_b_taken) begin
                    f_pc_d  = b_target;
                    state_d = StReq;
                end else if (pop) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            f_pc_q    <= RESET_PC;
            r_pc_q    <= '0;
            discard_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            f_pc_q    <= f_pc_d;
            r_pc_q    <= r_pc_d;
            discard_q <= discard_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= Nop;
            end
        end else if (i_b_taken) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]   <= r_pc_q;
                fifo_inst_q[wr_ptr_q] <= i_mem_rdata;
                wr_ptr_q              <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stage_1.sv
// Bench for stage_1: a directed cycle table for the multi-cycle corner cases, then random
// memory latency/grant/stall/redirect traffic checked against an in-order program-stream model.
module tb_stage_1;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        b_taken;
    logic [31:0] b_pc;
    logic        stall;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] Nop = 32'h0000_0013;

    stage_1 #(
        .RESET_PC  (32'h0000_0100),
        .FIFO_DEPTH(2)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .o_mem_req  (mem_req),
        .o_mem_addr (mem_addr),
        .i_mem_gnt  (mem_gnt),
        .i_mem_valid(mem_valid),
        .i_mem_rdata(mem_rdata),
        .i_b_taken  (b_taken),
        .i_b_pc     (b_pc),
        .i_stall    (stall),
        .o_valid    (valid),
        .o_inst     (inst),
        .o_pc       (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: every word address holds a distinct, non-NOP pattern.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        gnt;
        logic        mv;
        logic [31:0] raddr;
        logic        stall;
        logic        bt;
        logic [31:0] bpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        chk_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic g, input logic mv, input logic [31:0] ra,
                       input logic st, input logic bt, input logic [31:0] bp,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_pc, input logic cd);
        vec_t v;
        v.rst_n = r;  v.gnt = g;  v.mv = mv;  v.raddr = ra;  v.stall = st;
        v.bt = bt;  v.bpc = bp;  v.e_req = e_req;  v.e_addr = e_addr;
        v.e_valid = e_valid;  v.e_pc = e_pc;  v.chk_data = cd;
        vecs.push_back(v);
    endtask

    // Random-phase state.
    logic        pend, mv_drv, req_prev, gnt_prev;
    logic [31:0] paddr, addr_prev, exp_pc;
    int          lat_cnt, pops;

    initial begin
        rst_n = 1'b0;  mem_gnt = 1'b0;  mem_valid = 1'b0;  mem_rdata = '0;
        b_taken = 1'b0;  b_pc = '0;  stall = 1'b0;

        // Each row: outputs expected before the next edge, inputs applied for that edge.
        //  rst gnt mv raddr        st bt bpc           req addr          v pc           chk
        // Basic fetch stream from RESET_PC.
        add(0, 0, 0, 0,            0, 0, 0,            0, 32'h100,       0, 0,            1);
        add(1, 0, 0, 0,            0, 0, 0,            0, 32'h100,       0, 0,            1);
        add(1, 1, 0, 0,            0, 0, 0,            1, 32'h100,       0, 0,            0);
        add(1, 1, 1, 32'h100,      0, 0, 0,            0, 32'h104,       0, 0,            0);
        add(1, 1, 0, 0,            0, 0, 0,            1, 32'h104,       1, 32'h100,      1);
        add(1, 1, 1, 32'h104,      0, 0, 0,            0, 32'h108,       0, 0,            0);
        add(1, 1, 0, 0,            0, 0, 0,            1, 32'h108,       1, 32'h104,      1);
        add(1, 1, 1, 32'h108,      0, 0, 0,            0, 32'h10C,       0, 0,            0);
        add(1, 0, 0, 0,            0, 0, 0,            1, 32'h10C,       1, 32'h108,      1);
        // Stall fills the FIFO, HOLD, then drain and resume.
        add(0, 0, 0, 0,            0, 0, 0,            0, 32'h100,       0, 0,            1);
        add(1, 1, 0, 0,            1, 0, 0,            0, 32'h100,       0, 0,            1);
        add(1, 1, 0, 0,            1, 0, 0,            1, 32'h100,       0, 0,            0);
        add(1, 1, 1, 32'h100,      1, 0, 0,            0, 32'h104,       0, 0,            0);
        add(1, 1, 0, 0,            1, 0, 0,            1, 32'h104,       1, 32'h100,      1);
        add(1, 1, 1, 32'h104,      1, 0, 0,            0, 32'h108,       1, 32'h100,      1);
        add(1, 1, 0, 0,            1, 0, 0,            0, 32'h108,       1, 32'h100,      1);
        add(1, 1, 0, 0,            0, 0, 0,            0, 32'h108,       1, 32'h100,      1);
        add(1, 1, 0, 0,            0, 0, 0,            1, 32'h108,       1, 32'h104,      1);
        add(1, 1, 1, 32'h108,      0, 0, 0,            0, 32'h10C,       0, 0,            0);
        add(1, 1, 0, 0,            0, 0, 0,            1, 32'h10C,       1, 32'h108,      1);
        // Redirect while waiting on a 5-cycle response.
        add(1, 0, 0, 0,            0, 1, 32'h2000,     0, 32'h110,       0, 0,            0);
        add(1, 0, 0, 0,            0, 0, 0,            0, 32'h2000,      0, 0,            0);
        add(1, 0, 0, 0,            0, 0, 0,            0, 32'h2000,      0, 0,            0);
        add(1, 0, 0, 0,            0, 0, 0,            0, 32'h2000,      0, 0,            0);
        add(1, 0, 1, 32'h10C,      0, 0, 0,            0, 32'h2000,      0, 0,            0);
        add(1, 1, 0, 0,            0, 0, 0,            1, 32'h2000,      0, 0,            0);
        add(1, 1, 1, 32'h2000,     0, 0, 0,            0, 32'h2004,      0, 0,            0);
        // Redirect to an unaligned target on the grant cycle.
        add(1, 1, 0, 0,            1, 1, 32'h3002,     1, 32'h2004,      1, 32'h2000,     1);
        add(1, 0, 1, 32'h2004,     1, 0, 0,            0, 32'h3000,      0, 0,            0);
        add(1, 1, 0, 0,            0, 0, 0,            1, 32'h3000,      0, 0,            0);
        add(1, 0, 1, 32'h3000,     0, 0, 0,            0, 32'h3004,      0, 0,            0);
        add(1, 1, 0, 0,            1, 0, 0,            1, 32'h3004,      1, 32'h3000,     1);
        // Redirect together with a response and a pop, one entry held.
        add(1, 0, 1, 32'h3004,     0, 1, 32'h4000,     0, 32'h3008,      1, 32'h3000,     1);
        add(1, 1, 0, 0,            0, 0, 0,            1, 32'h4000,      0, 0,            0);
        add(1, 0, 1, 32'h4000,     0, 0, 0,            0, 32'h4004,      0, 0,            0);
        add(1, 0, 0, 0,            0, 0, 0,            1, 32'h4004,      1, 32'h4000,     1);
        // Redirect without grant, then fetch across the 32-bit wrap.
        add(1, 0, 0, 0,            0, 1, 32'hFFFF_FFFC, 1, 32'h4004,     0, 0,            0);
        add(1, 1, 0, 0,            0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,            0);
        add(1, 0, 1, 32'hFFFF_FFFC, 1, 0, 0,           0, 32'h0,         0, 0,            0);
        add(1, 1, 0, 0,            1, 0, 0,            1, 32'h0,         1, 32'hFFFF_FFFC, 1);
        add(1, 0, 0, 0,            1, 0, 0,            0, 32'h4,         1, 32'hFFFF_FFFC, 1);
        // Asynchronous reset mid-response, then a stray response in IDLE/REQ.
        add(0, 0, 0, 0,            0, 0, 0,            0, 32'h100,       0, 0,            1);
        add(1, 0, 1, 32'h0,        0, 0, 0,            0, 32'h100,       0, 0,            1);
        add(1, 0, 1, 32'h0,        0, 0, 0,            1, 32'h100,       0, 0,            1);
        add(1, 0, 0, 0,            0, 0, 0,            1, 32'h100,       0, 0,            1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            #1;
            chk($sformatf("row%0d req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("row%0d addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("row%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].chk_data) begin
                chk($sformatf("row%0d pc", i), pc, vecs[i].e_pc);
                chk($sformatf("row%0d inst", i), inst,
                    vecs[i].e_valid ? inst_of(vecs[i].e_pc) : Nop);
            end
            mem_gnt   = vecs[i].gnt;
            mem_valid = vecs[i].mv;
            mem_rdata = vecs[i].mv ? inst_of(vecs[i].raddr) : 32'hDEAD_BEEF;
            stall     = vecs[i].stall;
            b_taken   = vecs[i].bt;
            b_pc      = vecs[i].bpc;
        end

        // Random traffic: memory responder plus an in-order program-stream model.
        @(negedge clk);
        rst_n = 1'b0;  mem_gnt = 1'b0;  mem_valid = 1'b0;  stall = 1'b0;  b_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h100;  pend = 1'b0;  mv_drv = 1'b0;  req_prev = 1'b0;  gnt_prev = 1'b0;
        paddr = '0;  addr_prev = '0;  lat_cnt = 0;  pops = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (mv_drv) pend = 1'b0;
            if (req_prev && gnt_prev) begin
                chk("one outstanding request", {31'b0, pend}, 32'd0);
                chk("request address aligned", {30'b0, addr_prev[1:0]}, 32'd0);
                pend    = 1'b1;
                paddr   = addr_prev;
                lat_cnt = $urandom_range(0, 3);
            end
            if (pend && lat_cnt == 0) begin
                mv_drv = 1'b1;
            end else begin
                mv_drv = 1'b0;
                if (pend) lat_cnt--;
            end
            mem_valid = mv_drv;
            mem_rdata = mv_drv ? inst_of(paddr) : $urandom;
            req_prev  = mem_req;
            addr_prev = mem_addr;
            gnt_prev  = ($urandom_range(0, 9) < 7);
            mem_gnt   = gnt_prev;
            stall     = ($urandom_range(0, 9) < 3);
            b_taken   = ($urandom_range(0, 29) == 0);
            b_pc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                    : $urandom;
            if (valid && !stall && !b_taken) begin
                chk("stream pc", pc, exp_pc);
                chk("stream inst", inst, inst_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (b_taken) exp_pc = b_pc & 32'hFFFF_FFFC;
        end
        checks++;
        if (pops < 200) begin
            failures++;
            $display("FAIL forward progress: got %0d instructions, expected at least 200", pops);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
